// File: rtl/id_stage_param.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_param
// Description : Parametrised decode stage for the in-order RISC-V core.
//               Sits between IF and EX. Holds the architectural register
//               file, generates immediates for all base formats, flags
//               unsupported opcodes / out-of-range register indices and
//               presents the decoded bundle through one valid/ready
//               pipeline register with flush.
//
// Parameters  : XLEN  datapath width, 32 or 64
//               NREG  architectural register count, 32 (RV-I) or 16 (RV-E)
//
// Build option: ID_BYPASS_EN - when defined, a write-back in the same cycle
//               as an accept is forwarded into the captured operands
//               (write-before-read). When undefined the capture sees the
//               pre-write register file value.
//
// Ports       : clk, rst            clock, asynchronous active-high reset
//               in_valid/in_ready   IF handshake
//               inst, in_pc         instruction word and its PC
//               flush               kill held and incoming instruction
//               wb_en/wb_rd/wb_data register write-back
//               out_valid/out_ready EX handshake
//               out_pc, opcode, func3, func7, rs1, rs2, rd,
//               data1, data2, imm_ext, illegal   decoded bundle
//
// Revision    : 1.0  initial parametrised release
// ============================================================================

module id_stage_param #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,

    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] data1,
    output logic [XLEN-1:0] data2,
    output logic [XLEN-1:0] imm_ext,
    output logic            illegal
);

    // ------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_REG32  = 7'b0111011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    // ------------------------------------------------------------------
    // Instruction field extraction
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_func3;
    logic [6:0] w_func7;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;

    assign w_opcode = inst[6:0];
    assign w_func3  = inst[14:12];
    assign w_func7  = inst[31:25];
    assign w_rs1    = inst[19:15];
    assign w_rs2    = inst[24:20];
    assign w_rd     = inst[11:7];

    // ------------------------------------------------------------------
    // Immediate generation. Every format fits in 32 bits with inst[31]
    // as its sign, so it is assembled at 32 bits and widened afterwards.
    // ------------------------------------------------------------------
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm_ext;

    always_comb begin
        w_imm32 = 32'd0;
        case (w_opcode)
            c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_IMM32:
                w_imm32 = {{20{inst[31]}}, inst[31:20]};
            c_OP_STORE:
                w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            c_OP_BRANCH:
                w_imm32 = {{19{inst[31]}}, inst[31], inst[7],
                           inst[30:25], inst[11:8], 1'b0};
            c_OP_LUI, c_OP_AUIPC:
                w_imm32 = {inst[31:12], 12'd0};
            c_OP_JAL:
                w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                           inst[20], inst[30:21], 1'b0};
            default:
                w_imm32 = 32'd0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_imm_xlen64
            assign w_imm_ext = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_imm_xlen32
            assign w_imm_ext = w_imm32;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Illegal detection: unknown opcode, RV64-only word ops on a 32-bit
    // datapath, or any register field beyond the implemented file. The
    // register check is applied to all three fields regardless of format.
    // ------------------------------------------------------------------
    logic w_op_known;
    logic w_op_rv64_only;
    logic w_reg_range_bad;
    logic w_illegal;

    always_comb begin
        w_op_known = 1'b0;
        case (w_opcode)
            c_OP_LOAD, c_OP_FENCE, c_OP_IMM, c_OP_AUIPC, c_OP_IMM32,
            c_OP_STORE, c_OP_REG, c_OP_LUI, c_OP_REG32, c_OP_BRANCH,
            c_OP_JALR, c_OP_JAL, c_OP_SYSTEM:
                w_op_known = 1'b1;
            default:
                w_op_known = 1'b0;
        endcase
    end

    assign w_op_rv64_only  = (XLEN == 32) &&
                             ((w_opcode == c_OP_IMM32) || (w_opcode == c_OP_REG32));
    assign w_reg_range_bad = (32'(w_rs1) >= NREG) ||
                             (32'(w_rs2) >= NREG) ||
                             (32'(w_rd)  >= NREG);
    assign w_illegal       = !w_op_known || w_op_rv64_only || w_reg_range_bad;

    // ------------------------------------------------------------------
    // Register file. Entry 0 stays at its reset value of zero; indices at
    // or above NREG have no storage, so their writes simply fall through.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_rf [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wb_en && (wb_rd == 5'(i))) begin
                    r_rf[i] <= wb_data;
                end
            end
        end
    end

    // Read ports: x0 and out-of-range indices return zero.
    logic [XLEN-1:0] w_rf_rd1;
    logic [XLEN-1:0] w_rf_rd2;

    always_comb begin
        w_rf_rd1 = '0;
        w_rf_rd2 = '0;
        for (int i = 1; i < NREG; i++) begin
            if (w_rs1 == 5'(i)) begin
                w_rf_rd1 = r_rf[i];
            end
            if (w_rs2 == 5'(i)) begin
                w_rf_rd2 = r_rf[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand selection at capture time
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_cap1;
    logic [XLEN-1:0] w_cap2;

`ifdef ID_BYPASS_EN
    // Forward a same-cycle write-back so the captured operand already
    // reflects the write that lands on this edge.
    assign w_cap1 = (wb_en && (wb_rd == w_rs1) && (w_rs1 != 5'd0)) ? wb_data : w_rf_rd1;
    assign w_cap2 = (wb_en && (wb_rd == w_rs2) && (w_rs2 != 5'd0)) ? wb_data : w_rf_rd2;
`else
    // Capture the pre-write value; the hazard unit covers the gap.
    assign w_cap1 = w_rf_rd1;
    assign w_cap2 = w_rf_rd2;
`endif

    // ------------------------------------------------------------------
    // Output pipeline register
    // ------------------------------------------------------------------
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [6:0]      r_opcode;
    logic [2:0]      r_func3;
    logic [6:0]      r_func7;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_data1;
    logic [XLEN-1:0] r_data2;
    logic [XLEN-1:0] r_imm_ext;
    logic            r_illegal;

    logic w_in_ready;
    logic w_accept;
    logic w_hold;
    logic w_refresh1;
    logic w_refresh2;

    assign w_in_ready = !r_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_hold     = r_valid && !out_ready;

    // A stalled bundle tracks write-backs to its own sources so that EX
    // never consumes an operand that went stale while it was waiting.
    assign w_refresh1 = w_hold && wb_en && (wb_rd == r_rs1) && (r_rs1 != 5'd0);
    assign w_refresh2 = w_hold && wb_en && (wb_rd == r_rs2) && (r_rs2 != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_opcode  <= '0;
            r_func3   <= '0;
            r_func7   <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_data1   <= '0;
            r_data2   <= '0;
            r_imm_ext <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            // Bundle fields are left as-is; only validity matters here.
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_pc      <= in_pc;
            r_opcode  <= w_opcode;
            r_func3   <= w_func3;
            r_func7   <= w_func7;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_data1   <= w_cap1;
            r_data2   <= w_cap2;
            r_imm_ext <= w_imm_ext;
            r_illegal <= w_illegal;
        end else begin
            if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_refresh1) begin
                r_data1 <= wb_data;
            end
            if (w_refresh2) begin
                r_data2 <= wb_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign opcode    = r_opcode;
    assign func3     = r_func3;
    assign func7     = r_func7;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign rd        = r_rd;
    assign data1     = r_data1;
    assign data2     = r_data2;
    assign imm_ext   = r_imm_ext;
    assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage_param
// Description : Directed self-checking bench for id_stage_param. Drives two
//               instances from shared stimulus: a 64-bit RV-I build and a
//               32-bit RV-E build (the latter sees the low 32 bits of the
//               wide buses).
// Revision    : 1.0  initial release
// ============================================================================

module tb_id_stage_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] inst;
    logic [63:0] in_pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [63:0] a_out_pc, a_data1, a_data2, a_imm;
    logic [6:0]  a_opcode, a_func7;
    logic [2:0]  a_func3;
    logic [4:0]  a_rs1, a_rs2, a_rd;

    logic        b_in_ready, b_out_valid, b_illegal;
    logic [31:0] b_out_pc, b_data1, b_data2, b_imm;
    logic [6:0]  b_opcode, b_func7;
    logic [2:0]  b_func3;
    logic [4:0]  b_rs1, b_rs2, b_rd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_stage_param #(.XLEN(64), .NREG(32)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready), .inst(inst), .in_pc(in_pc),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
        .opcode(a_opcode), .func3(a_func3), .func7(a_func7),
        .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd),
        .data1(a_data1), .data2(a_data2), .imm_ext(a_imm), .illegal(a_illegal)
    );

    id_stage_param #(.XLEN(32), .NREG(16)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready), .inst(inst), .in_pc(in_pc[31:0]),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data[31:0]),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
        .opcode(b_opcode), .func3(b_func3), .func7(b_func7),
        .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
        .data1(b_data1), .data2(b_data2), .imm_ext(b_imm), .illegal(b_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef ID_BYPASS_EN
    localparam logic [63:0] c_BYP_EXP = 64'h55;
`else
    localparam logic [63:0] c_BYP_EXP = 64'h11;
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; inst = '0; in_pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid_a", 64'(a_out_valid), 64'd0);
        chk("rst_valid_b", 64'(b_out_valid), 64'd0);
        chk("rst_data1_a", a_data1, 64'd0);
        chk("rst_imm_a",   a_imm,   64'd0);
        chk("rst_inready", 64'(a_in_ready), 64'd1);
        rst = 1'b0;

        // x5 = 0x1234, then add x7,x5,x0
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234; tick(); wb_en = 1'b0;
        in_valid = 1'b1; inst = 32'h000283B3; in_pc = 64'h100; tick(); in_valid = 1'b0;
        chk("add_valid",  64'(a_out_valid), 64'd1);
        chk("add_data1",  a_data1, 64'h1234);
        chk("add_data2",  a_data2, 64'd0);
        chk("add_imm",    a_imm,   64'd0);
        chk("add_rs1",    64'(a_rs1), 64'd5);
        chk("add_rd",     64'(a_rd),  64'd7);
        chk("add_opcode", 64'(a_opcode), 64'h33);
        chk("add_pc",     a_out_pc, 64'h100);
        chk("add_ill",    64'(a_illegal), 64'd0);
        chk("add_data1_b", 64'(b_data1), 64'h1234);
        chk("add_ill_b",  64'(b_illegal), 64'd0);
        tick();
        chk("xfer_valid", 64'(a_out_valid), 64'd0);

        // Immediate formats, back-to-back accepts
        in_valid = 1'b1; inst = 32'hFFF00093; tick();
        chk("imm_i_a", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("imm_i_b", 64'(b_imm), 64'hFFFF_FFFF);
        chk("imm_i_rd", 64'(a_rd), 64'd1);
        inst = 32'h800000B7; tick();
        chk("imm_u_a", a_imm, 64'hFFFF_FFFF_8000_0000);
        chk("imm_u_b", 64'(b_imm), 64'h8000_0000);
        inst = 32'hFE112E23; tick();
        chk("imm_s_a", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("imm_s_b", 64'(b_imm), 64'hFFFF_FFFC);
        inst = 32'hFE000FE3; tick();
        chk("imm_b_a", a_imm, 64'hFFFF_FFFF_FFFF_FFFE);
        inst = 32'h001000EF; tick();
        chk("imm_j_a", a_imm, 64'h800);

        // Stall with stale-operand refresh: add x8,x3,x0
        inst = 32'h00018433; in_pc = 64'h200; tick();
        in_valid = 1'b0; out_ready = 1'b0; #1;
        chk("stall_inready", 64'(a_in_ready), 64'd0);
        chk("stall_data1_pre", a_data1, 64'd0);
        chk("stall_rs1", 64'(a_rs1), 64'd3);
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'hAB; in_valid = 1'b1; inst = 32'h800000B7;
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        chk("refresh_data1",   a_data1, 64'hAB);
        chk("refresh_data1_b", 64'(b_data1), 64'hAB);
        chk("refresh_data2",   a_data2, 64'd0);
        chk("refresh_valid",   64'(a_out_valid), 64'd1);
        chk("refresh_inready", 64'(a_in_ready), 64'd0);
        chk("refresh_opcode",  64'(a_opcode), 64'h33);
        chk("refresh_rd",      64'(a_rd), 64'd8);
        chk("refresh_pc",      a_out_pc, 64'h200);
        out_ready = 1'b1; tick();
        chk("release_valid", 64'(a_out_valid), 64'd0);

        // Same-cycle write vs capture: add x10,x9,x9
        wb_en = 1'b1; wb_rd = 5'd9; wb_data = 64'h11; tick();
        wb_data = 64'h55; in_valid = 1'b1; inst = 32'h00948533; tick(); wb_en = 1'b0;
        chk("byp_data1",   a_data1, c_BYP_EXP);
        chk("byp_data2",   a_data2, c_BYP_EXP);
        chk("byp_data1_b", 64'(b_data1), c_BYP_EXP);
        tick();
        chk("after_wr_data1", a_data1, 64'h55);

        // Write to x0 is dropped: add x11,x0,x0
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hDEAD; inst = 32'h000005B3; tick(); wb_en = 1'b0;
        chk("x0_data1",   a_data1, 64'd0);
        chk("x0_data2",   a_data2, 64'd0);
        chk("x0_data1_b", 64'(b_data1), 64'd0);

        // Flush with accept; RF write in the same cycle still lands
        flush = 1'b1; wb_en = 1'b1; wb_rd = 5'd12; wb_data = 64'h77; inst = 32'h00060633; tick();
        flush = 1'b0; wb_en = 1'b0;
        chk("flush_valid_a", 64'(a_out_valid), 64'd0);
        chk("flush_valid_b", 64'(b_out_valid), 64'd0);
        tick();
        chk("flush_rf_data1", a_data1, 64'h77);
        chk("flush_rf_valid", 64'(a_out_valid), 64'd1);

        // Illegal flagging
        inst = 32'h01000813; tick();
        chk("ill_rd16_a",    64'(a_illegal), 64'd0);
        chk("ill_rd16_b",    64'(b_illegal), 64'd1);
        chk("ill_rd16_vb",   64'(b_out_valid), 64'd1);
        chk("ill_rd16_rd",   64'(a_rd), 64'd16);
        inst = 32'h0000001B; tick();
        chk("ill_w_a", 64'(a_illegal), 64'd0);
        chk("ill_w_b", 64'(b_illegal), 64'd1);
        inst = 32'h0000007F; tick();
        chk("ill_op_a", 64'(a_illegal), 64'd1);
        chk("ill_op_b", 64'(b_illegal), 64'd1);

        // Reset mid-stream: addi x5,x5,1 held in the bundle
        inst = 32'h00128293; tick(); in_valid = 1'b0;
        chk("pre_rst_data1", a_data1, 64'h1234);
        chk("pre_rst_imm",   a_imm,   64'd1);
        rst = 1'b1; #1;
        chk("mid_rst_valid",   64'(a_out_valid), 64'd0);
        chk("mid_rst_data1",   a_data1, 64'd0);
        chk("mid_rst_imm",     a_imm,   64'd0);
        chk("mid_rst_data1_b", 64'(b_data1), 64'd0);
        tick(); rst = 1'b0;
        in_valid = 1'b1; inst = 32'h000283B3; tick(); in_valid = 1'b0;
        chk("post_rst_valid", 64'(a_out_valid), 64'd1);
        chk("post_rst_x5",    a_data1, 64'd0);
        chk("post_rst_x5_b",  64'(b_data1), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
Parametrised decode stage for the in-order RISC-V core. It sits between IF and EX and holds:
- the architectural register file (NREG x XLEN);
- immediate generation for all base formats;
- a single valid/ready output pipeline register with flush.

It replaces the fixed 64-bit decode stage, and adds stall handling, flush, write-back bypass and illegal-opcode flagging.

Parameters:
XLEN, 64, datapath width; 32 or 64 only.
NREG, 32, architectural register count; 32 (RV-I) or 16 (RV-E).

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  IF presents an instruction.
in_ready  out  1  stage can accept this cycle.
inst  in  32  instruction word.
in_pc  in  XLEN  PC of inst.
flush  in  1  kill the held instruction and the one being accepted.
wb_en  in  1  register write-back enable.
wb_rd  in  5  write-back destination.
wb_data  in  XLEN  write-back value.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  EX accepts the bundle.
out_pc  out  XLEN  PC of the decoded instruction.
opcode  out  7  inst[6:0].
func3  out  3  inst[14:12].
func7  out  7  inst[31:25].
rs1, rs2, rd  out  5 each  register indices.
data1, data2  out  XLEN  source operands.
imm_ext  out  XLEN  sign-extended immediate.
illegal  out  1  unsupported opcode or out-of-range register index.

Behaviour:
- Reset (async, asserted): out_valid=0; all other outputs 0; all RF entries 0. Deassertion takes effect at the next posedge.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Latency: one cycle from accept to out_valid=1.
- On accept (no flush), at posedge capture:
  - out_pc, opcode, func3, func7, rs1, rs2, rd, imm_ext, illegal;
  - data1=RF[rs1], data2=RF[rs2]; reads of x0 return 0.
- Transfer: out_valid && out_ready with no new accept -> out_valid=0 next cycle.
- Stall: out_valid && !out_ready -> bundle held stable, except the stale-operand refresh below.
- Stale-operand refresh (always on): while holding, if wb_en and wb_rd==rs1 and rs1!=0, then data1 <= wb_data. Same rule for data2/rs2.
- Flush: has priority over accept. Next cycle out_valid=0 and bundle fields are don't-care. RF writes in the same cycle still occur.
- RF write: at posedge, when wb_en and wb_rd!=0, RF[wb_rd] <= wb_data. Writes to x0 are ignored. When NREG=16, writes with wb_rd>=16 are ignored.
- Immediates (sign bit inst[31], extended to XLEN):
  - I (0010011, 0000011, 1100111, 0011011): inst[31:20].
  - S (0100011): {inst[31:25], inst[11:7]}.
  - B (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U (0110111, 0010111): {inst[31:12], 12'b0}, sign-extended when XLEN=64.
  - J (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R (0110011, 0111011) and others: 0.
- Illegal: illegal=1 if opcode is not in the list above plus 0001111/1110011.
  - When XLEN=32, opcodes 0011011/0111011 are also illegal.
  - When NREG=16, any of rs1/rs2/rd >= 16 is illegal.
  - Illegal instructions still flow (out_valid=1); EX raises the trap.

Optional Feature:
ID_BYPASS_EN
- Defined: on accept, if wb_en and wb_rd==rs1 (nonzero), data1 takes wb_data instead of the RF value. Same for data2/rs2. Gives write-before-read semantics.
- Undefined: the capture reads the pre-write RF value. The hazard unit must stall one extra cycle.
- The stale-operand refresh is unaffected either way.

Test Plan:
- Reset mid-stream: assert rst while out_valid=1 -> out_valid=0, data1=0, imm_ext=0 immediately; RF[5] reads 0 afterwards.
- Write x5=0x1234, then accept add x7,x5,x0 -> one cycle later out_valid=1, data1=0x1234, data2=0, imm_ext=0.
- Immediates: inst 0xFFF00093 (addi x1,x0,-1) -> imm_ext=all ones. 0x800000B7 (lui) with XLEN=64 -> imm_ext=0xFFFFFFFF80000000. With XLEN=32 -> 0x80000000.
- Stall + refresh: hold out_ready=0 with bundle rs1=3; pulse wb_en, wb_rd=3, wb_data=0xAB -> data1=0xAB next cycle. in_ready=0 throughout; bundle otherwise unchanged.
- Same-cycle bypass: accept rs1=9 while wb_en, wb_rd=9, wb_data=0x55 -> data1=0x55 with ID_BYPASS_EN, old RF[9] without. A write to x0 leaves data=0.
- Flush and illegal: flush asserted together with in_valid -> out_valid=0 next cycle. With NREG=16, inst 0x01000813 (rd=16) -> illegal=1, out_valid=1.
